// File: rtl/router_pkg.sv
// Shared types and header field layout for the router output channel.
// Holds the reader FSM states, header bit positions and byte-count helpers.
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int DEST_MSB = 1;
  localparam int LEN_LSB  = DEST_MSB + 1;
  localparam int LEN_MSB  = 7;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
  // Must hold L+1 for the largest L, so one bit wider than the length field.
  localparam int CNT_W    = LEN_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    OUT,
    STALL
  } state_e;

  // Bytes still to come after the header: L payload bytes plus parity.
  function automatic logic [CNT_W-1:0] pkt_remain(
    input logic [DATA_W-1:0] hdr
  );
    return {1'b0, hdr[LEN_MSB:LEN_LSB]} + CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_out_timeout.sv
// Stall watchdog: counts consecutive stalled output cycles and fires a flush.
// Ports: clk, rst, stall_i (valid held without ready), fire_o (flush pulse).
module router_out_timeout #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  output logic fire_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // fire_o marks the stalled cycle whose count reaches TIMEOUT; a ready in
  // that cycle drops stall_i, so the handshake wins over the flush.
  assign fire_o = stall_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = 8'd0;
    if (stall_i && !fire_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/router_out_reader.sv
// Read engine for one router output: drains FIFO bytes onto a valid/ready port.
// Ports: clk/rst, FIFO read side (fifo_empty, fifo_dout, fifo_rd_en,
// fifo_soft_rst), stream out (m_data, m_valid, m_ready, m_sop, m_eop),
// status (pkt_err, busy). Macro ROUTER_PARITY_CHECK_EN builds the parity check.
module router_out_reader
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              fifo_soft_rst,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sop,
  output logic              m_eop,
  output logic              pkt_err,
  output logic              busy
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              first_q;
  logic              first_d;

  logic in_out;
  logic hs;
  logic last;
  logic fire;

  assign in_out = (state_q == OUT);
  assign hs     = in_out && m_ready;
  // Header is never last; the counter only means something after it.
  assign last   = !first_q && (cnt_q == CNT_W'(1));

  router_out_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .stall_i (in_out && !m_ready),
    .fire_o  (fire)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        first_d = 1'b1;
        if (!fifo_empty) begin
          state_d = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        data_d  = fifo_dout;
        state_d = OUT;
      end
      OUT: begin
        if (m_ready) begin
          first_d = 1'b0;
          if (first_q) begin
            cnt_d = pkt_remain(data_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (last) begin
            state_d = IDLE;
          end else if (!fifo_empty) begin
            state_d = RD;
          end else begin
            state_d = STALL;
          end
        end else if (fire) begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (!fifo_empty) begin
          state_d = RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] xor_q;
  logic [DATA_W-1:0] xor_d;

  always_comb begin
    xor_d = xor_q;
    if (hs) begin
      xor_d = first_q ? data_q : (xor_q ^ data_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end

  assign pkt_err = hs && last && (xor_q != data_q);
`else
  assign pkt_err = 1'b0;
`endif

  assign fifo_rd_en    = (state_q == RD);
  assign fifo_soft_rst = fire;
  assign m_data        = data_q;
  assign m_valid       = in_out;
  assign m_sop         = in_out && first_q;
  assign m_eop         = in_out && last;
  assign busy          = (state_q != IDLE);

endmodule
